// File: rtl/sram_fifo_ctrl_150b_512_if.sv
// Push and pop valid/ready streams of the SRAM-backed FIFO controller.
// The master drives pushes and consumes pops; the controller is the slave.
interface sram_fifo_ctrl_150b_512_if #(
  parameter int DATA_WIDTH = 150
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sram_fifo_ctrl_150b_512.sv
// Streaming FIFO controller time-sharing one single-port 150x512 SRAM macro
// between pushes and pops, with a small shift-register prefetch buffer on the pop side.
module sram_fifo_ctrl_150b_512 #(
  parameter int DATA_WIDTH = 150,
  parameter int ADDR_WIDTH = 9,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                      clk0,
  input  logic                      rst_n,
  sram_fifo_ctrl_150b_512_if.slave  bus,
  output logic [ADDR_WIDTH:0]       level,
  output logic                      sram_csb0,
  output logic                      sram_web0,
  output logic [ADDR_WIDTH-1:0]     sram_addr0,
  output logic [DATA_WIDTH-1:0]     sram_din0,
  input  logic [DATA_WIDTH-1:0]     sram_dout0
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OB_W  = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } sram_op_e;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CNT_W-1:0]      sram_cnt;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
  logic [OB_W-1:0]       obuf_cnt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] din_hold;

  sram_op_e              op;
  logic                  rd_issue;
  logic                  push_ready;
  logic                  pop;
  logic                  capture;
  logic [OB_W:0]         obuf_claimed;
  logic [OB_W-1:0]       obuf_wr_idx;

  // A read is only worth issuing while its result is guaranteed a slot in obuf.
  assign obuf_claimed = {1'b0, obuf_cnt} + (OB_W+1)'(rd_inflight);
  assign rd_issue     = rst_n && (sram_cnt != '0) &&
                        (obuf_claimed < (OB_W+1)'(OBUF_DEPTH));
  assign push_ready   = rst_n && (sram_cnt < CNT_W'(DEPTH)) && !rd_issue;

  assign bus.in_ready  = push_ready;
  assign bus.out_valid = (obuf_cnt != '0);
  assign bus.out_data  = obuf[0];

  assign pop         = bus.out_valid && bus.out_ready;
  assign capture     = rd_inflight;
  assign obuf_wr_idx = obuf_cnt - OB_W'(pop);

  assign level = sram_cnt + CNT_W'(rd_inflight) + CNT_W'(obuf_cnt);

  always_comb begin
    op = OP_IDLE;
    if (rd_issue) begin
      op = OP_READ;
    end else if (bus.in_valid && push_ready) begin
      op = OP_WRITE;
    end
  end

  // Idle cycles keep address and data pins parked on the last issued values.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = addr_hold;
    sram_din0  = din_hold;
    case (op)
      OP_READ: begin
        sram_csb0  = 1'b0;
        sram_addr0 = rptr;
      end
      OP_WRITE: begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = wptr;
        sram_din0  = bus.in_data;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
      obuf_cnt    <= '0;
      addr_hold   <= '0;
      din_hold    <= '0;
    end else begin
      case (op)
        OP_READ: begin
          rptr      <= rptr + 1'b1;
          sram_cnt  <= sram_cnt - 1'b1;
          addr_hold <= rptr;
        end
        OP_WRITE: begin
          wptr      <= wptr + 1'b1;
          sram_cnt  <= sram_cnt + 1'b1;
          addr_hold <= wptr;
          din_hold  <= bus.in_data;
        end
        default: begin
        end
      endcase
      rd_inflight <= (op == OP_READ);
      obuf_cnt    <= obuf_cnt + OB_W'(capture) - OB_W'(pop);
    end
  end

  // Captured read data lands behind the surviving entries, so a simultaneous pop keeps order.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (capture && (obuf_wr_idx == OB_W'(i))) begin
          obuf[i] <= sram_dout0;
        end else if (pop) begin
          obuf[i] <= obuf[(i < OBUF_DEPTH-1) ? i+1 : i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl_150b_512.sv
// Self-checking bench: queue reference model of the FIFO plus a behavioural model of the
// SRAM macro whose read data is only valid between the negedge and the next posedge.
module tb_sram_fifo_ctrl_150b_512;

  localparam int DW    = 150;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int OBD   = 3;
  localparam int CAP   = DEPTH + OBD;

  logic          clk0 = 1'b0;
  logic          rst_n;
  logic [AW:0]   level;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  sram_fifo_ctrl_150b_512_if #(.DATA_WIDTH(DW)) bus ();

  sram_fifo_ctrl_150b_512 #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OBUF_DEPTH(OBD)
  ) dut (
    .clk0       (clk0),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Macro model: junk on dout right after each posedge, real data after the negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  always @(posedge clk0 or negedge clk0) begin
    if (clk0) begin
      sram_dout0 <= rand_word();
      rd_pend    <= !sram_csb0 && sram_web0;
      rd_addr    <= sram_addr0;
      if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    end else if (rd_pend) begin
      sram_dout0 <= mem[rd_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [$];
  int            n_push = 0;
  int            n_pop  = 0;
  int            low_run = 0;
  logic          pushed, popped;
  logic [DW-1:0] last_pop;
  logic          s_in_ready, s_out_valid, s_csb, s_web;
  int            s_level;
  logic [DW-1:0] s_out_data;
  logic          seen_top = 1'b0;
  logic          wrapped  = 1'b0;
  int            max_level = 0;

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    s_csb       = sram_csb0;
    s_web       = sram_web0;
    s_level     = int'(level);
    if (s_level > max_level) max_level = s_level;
    checkInt("level_vs_model", s_level, q.size());
    if (s_out_valid) begin
      if (q.size() > 0) checkVal("head_data", s_out_data, q[0]);
      else checkInt("out_valid_when_empty", int'(s_out_valid), 0);
    end
    if (s_in_ready) checkInt("in_ready_below_capacity", int'(q.size() < CAP), 1);
    if (!rst_n) begin
      checkInt("in_ready_in_reset", int'(s_in_ready), 0);
      checkInt("csb_in_reset", int'(s_csb), 1);
    end
    if (bus.in_valid && s_in_ready) begin
      checkInt("push_drives_write", int'(!s_csb && !s_web), 1);
      checkVal("write_din", sram_din0, bus.in_data);
    end
    if (!s_csb) begin
      if (sram_addr0 == AW'(DEPTH-1)) seen_top = 1'b1;
      else if (seen_top && sram_addr0 == '0) wrapped = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] data, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = data;
    bus.out_ready = ordy;
    @(negedge clk0);
    checkOutput();
    if (rst_n && !ordy && !s_in_ready && s_level < DEPTH) low_run++;
    else low_run = 0;
    if (rst_n && !ordy) checkInt("starvation_bound", int'(low_run <= OBD), 1);
    pushed = iv && s_in_ready;
    popped = s_out_valid && ordy;
    @(posedge clk0);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (popped && q.size() > 0) void'(q.pop_front());
      if (pushed) q.push_back(data);
    end
    if (pushed) n_push++;
    if (popped) begin
      n_pop++;
      last_pop = s_out_data;
    end
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] data;
    logic          ordy;
    logic          e_in_ready;
    logic          e_out_valid;
    int            e_level;
    logic          e_csb;
    logic          e_web;
  } vec_t;

  vec_t          vecs [5];
  logic [DW-1:0] a5_word;
  logic [DW-1:0] stale_word;
  logic [DW-1:0] fresh_word;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc, pops, cnt;

    a5_word       = rand_word();
    a5_word[7:0]  = 8'hA5;
    vecs[0] = '{1'b1, a5_word, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, '0,      1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, '0,      1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, '0,      1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, '0,      1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk0);
    #1;

    $display("[TB] reset hold");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, rand_word(), 1'b0);
      checkInt("rst_in_ready", int'(s_in_ready), 0);
      checkInt("rst_csb0", int'(s_csb), 1);
      checkInt("rst_out_valid", int'(s_out_valid), 0);
      checkInt("rst_level", s_level, 0);
    end
    rst_n = 1'b1;

    $display("[TB] push-to-pop latency table");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k].iv, vecs[k].data, vecs[k].ordy);
      checkInt("lat_in_ready", int'(s_in_ready), int'(vecs[k].e_in_ready));
      checkInt("lat_out_valid", int'(s_out_valid), int'(vecs[k].e_out_valid));
      checkInt("lat_level", s_level, vecs[k].e_level);
      checkInt("lat_csb0", int'(s_csb), int'(vecs[k].e_csb));
      checkInt("lat_web0", int'(s_web), int'(vecs[k].e_web));
      if (vecs[k].e_out_valid) checkVal("lat_data", s_out_data, a5_word);
    end

    $display("[TB] fill to full");
    acc = 0;
    for (int c = 0; c < 700; c++) begin
      applyStimulus(1'b1, DW'(acc), 1'b0);
      if (pushed) acc++;
    end
    checkInt("fill_accepted", acc, CAP);
    applyStimulus(1'b0, '0, 1'b0);
    checkInt("full_in_ready", int'(s_in_ready), 0);
    checkInt("full_level", s_level, CAP);
    pops = 0;
    for (int c = 0; c < 700 && pops < CAP; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (popped) begin
        checkVal("fill_order", last_pop, DW'(pops));
        pops++;
      end
    end
    checkInt("fill_drained", pops, CAP);

    $display("[TB] pointer wrap rounds");
    seen_top = 1'b0;
    wrapped  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      for (int c = 0; c < 600 && cnt < 400; c++) begin
        applyStimulus(1'b1, rand_word(), 1'b0);
        if (pushed) cnt++;
      end
      checkInt("wrap_pushed", cnt, 400);
      cnt = 0;
      for (int c = 0; c < 600 && cnt < 400; c++) begin
        applyStimulus(1'b0, '0, 1'b1);
        if (popped) cnt++;
      end
      checkInt("wrap_popped", cnt, 400);
    end
    checkInt("addr_wrapped", int'(wrapped), 1);

    $display("[TB] contention");
    n_push    = 0;
    n_pop     = 0;
    max_level = 0;
    for (int c = 0; c < 2000; c++) applyStimulus(1'b1, rand_word(), 1'b1);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 2) == 0));
    end
    for (int c = 0; c < 700 && q.size() > 0; c++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkInt("conservation", n_pop, n_push);
    checkInt("drained_level", s_level, 0);
    checkInt("level_max_ok", int'(max_level <= CAP), 1);

    $display("[TB] reset during read");
    stale_word = rand_word();
    fresh_word = ~stale_word;
    applyStimulus(1'b1, stale_word, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkInt("mid_read_issued", int'(!s_csb && s_web), 1);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkInt("mid_rst_out_valid", int'(s_out_valid), 0);
    checkInt("mid_rst_level", s_level, 0);
    n_pop = 0;
    applyStimulus(1'b1, fresh_word, 1'b1);
    for (int c = 0; c < 12; c++) applyStimulus(1'b0, '0, 1'b1);
    checkInt("fresh_pop_count", n_pop, 1);
    checkVal("fresh_pop_value", last_pop, fresh_word);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
